lcd_text_sequencer: RTL and testbench

- Owns a 32-character text frame buffer (2 lines x 16) written by the host logic.
- On a refresh request, streams the frame byte by byte into the character LCD driver through that driver's ready/write-enable handshake.
- Sits between application logic and the LCD driver. It is the only block that drives the driver's write_Enabled and iData inputs.

---
 rtl/lcd_text_sequencer.sv | 137 +++++++++++++
 tb/tb_lcd_text_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer.sv
// Character LCD frame sequencer: 2x16 text buffer written by the host, streamed byte by byte
// through the driver's ready/write-enable handshake on refresh; sticky error on ack timeout.
module lcd_text_sequencer #(
    parameter int P_NUM_CHARS    = 32,
    parameter int P_ACK_TIMEOUT  = 8,
    parameter bit P_AUTO_REFRESH = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWriteEnable,
    input  logic [4:0] iWriteAddr,
    input  logic [7:0] iWriteChar,
    input  logic       iRefresh,
    input  logic       iLCD_Ready,
    output logic       oLCD_WriteEnable,
    output logic [7:0] oLCD_Data,
    output logic       oBusy,
    output logic       oFrameDone,
    output logic       oError
);

    localparam int CW = (P_ACK_TIMEOUT > 1) ? $clog2(P_ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    logic [7:0]    buf_q [P_NUM_CHARS];
    state_t        state_q;
    logic [4:0]    idx_q;
    logic          pending_q;
    logic          pending_d;
    logic [CW-1:0] tmo_q;
    logic          we_q;
    logic [7:0]    data_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          wr_ok;
    logic          req;
    logic          depart;
    logic          last;
    logic [4:0]    idx_nxt;

    assign wr_ok   = iWriteEnable && ({1'b0, iWriteAddr} < 6'(P_NUM_CHARS));
    assign req     = iRefresh || (P_AUTO_REFRESH && wr_ok);
    assign depart  = (state_q == S_IDLE) && pending_q && iLCD_Ready;
    // A request sampled on the departure edge survives, so it buys one more frame.
    assign pending_d = req || (pending_q && !depart);
    assign last    = (idx_q == 5'(P_NUM_CHARS - 1));
    assign idx_nxt = idx_q + 5'd1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < P_NUM_CHARS; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else if (wr_ok) begin
            buf_q[iWriteAddr] <= iWriteChar;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 5'd0;
            pending_q <= 1'b0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (depart) begin
                        idx_q   <= 5'd0;
                        data_q  <= buf_q[0];
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Entry always happens on a ready edge, so the strobe is raised on entry.
                    if (we_q) begin
                        we_q    <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_WAIT_ACK;
                    end else if (iLCD_Ready) begin
                        we_q <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (!iLCD_Ready) begin
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_q == CW'(P_ACK_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (iLCD_Ready) begin
                        if (last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_nxt;
                            data_q  <= buf_q[idx_nxt];
                            we_q    <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oLCD_WriteEnable = we_q;
    assign oLCD_Data        = data_q;
    assign oBusy            = busy_q;
    assign oFrameDone       = done_q;
    assign oError           = err_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Randomized bench: two sequencer instances (manual and auto refresh) against a behavioural driver model.
module tb_lcd_text_sequencer;

    logic       clk = 1'b0;
    logic       rst     [2];
    logic       wen     [2];
    logic [4:0] waddr   [2];
    logic [7:0] wchar   [2];
    logic       refresh [2];
    logic       rdy     [2];
    logic       lwe     [2];
    logic [7:0] ldat    [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ndone   [2];
    int         fixlen  [2];
    bit         stuck   [2];
    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    logic [7:0] mbuf [32];

    always #10 clk = ~clk;

    lcd_text_sequencer #(.P_NUM_CHARS(32), .P_ACK_TIMEOUT(8), .P_AUTO_REFRESH(1'b0)) dut (
        .Clock(clk), .Reset(rst[0]), .iWriteEnable(wen[0]), .iWriteAddr(waddr[0]),
        .iWriteChar(wchar[0]), .iRefresh(refresh[0]), .iLCD_Ready(rdy[0]),
        .oLCD_WriteEnable(lwe[0]), .oLCD_Data(ldat[0]), .oBusy(busy[0]),
        .oFrameDone(done[0]), .oError(err[0])
    );

    lcd_text_sequencer #(.P_NUM_CHARS(32), .P_ACK_TIMEOUT(8), .P_AUTO_REFRESH(1'b1)) dut_ar (
        .Clock(clk), .Reset(rst[1]), .iWriteEnable(wen[1]), .iWriteAddr(waddr[1]),
        .iWriteChar(wchar[1]), .iRefresh(refresh[1]), .iLCD_Ready(rdy[1]),
        .oLCD_WriteEnable(lwe[1]), .oLCD_Data(ldat[1]), .oBusy(busy[1]),
        .oFrameDone(done[1]), .oError(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Driver model: after a sampled strobe, ready drops for a busy period (fixed or random).
    initial begin
        int  bcnt [2];
        bit  seen [2];
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        bcnt[0] = 0;
        bcnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) seen[i] = lwe[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (stuck[i]) begin
                    rdy[i]  = 1'b1;
                    bcnt[i] = 0;
                end else if (seen[i]) begin
                    rdy[i]  = 1'b0;
                    bcnt[i] = (fixlen[i] > 0) ? fixlen[i] : int'($urandom_range(1, 6));
                end else if (bcnt[i] > 0) begin
                    bcnt[i]--;
                    if (bcnt[i] == 0) rdy[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        bit prev [2];
        prev[0] = 1'b0;
        prev[1] = 1'b0;
        ndone[0] = 0;
        ndone[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (lwe[i] === 1'b1) begin
                    chk("we_while_ready", rdy[i], 1'b1);
                    chk("we_back_to_back", prev[i], 1'b0);
                    if (i == 0) cap0.push_back(ldat[i]);
                    else        cap1.push_back(ldat[i]);
                end
                prev[i] = (lwe[i] === 1'b1);
                if (done[i] === 1'b1) ndone[i]++;
            end
        end
    end

    function automatic int csz(input int w);
        return (w == 0) ? cap0.size() : cap1.size();
    endfunction

    task automatic hwrite(input int w, input logic [4:0] a, input logic [7:0] c);
        wen[w]   = 1'b1;
        waddr[w] = a;
        wchar[w] = c;
        step();
        wen[w]   = 1'b0;
        if (w == 0) mbuf[a] = c;
    endtask

    task automatic rfr(input int w);
        refresh[w] = 1'b1;
        step();
        refresh[w] = 1'b0;
    endtask

    task automatic wait_frames(input int w, input int target, input int budget);
        int c;
        c = 0;
        while (ndone[w] < target && c < budget) begin
            step();
            c++;
        end
        chk("frame_wait", ndone[w] >= target, 1'b1);
    endtask

    task automatic wait_cap(input int w, input int n, input int budget);
        int c;
        c = 0;
        while (csz(w) < n && c < budget) begin
            step();
            c++;
        end
        chk("byte_wait", csz(w) >= n, 1'b1);
    endtask

    task automatic cmp_frame(input int w, input int base, input logic [7:0] exp [32]);
        chk("frame_len", csz(w) >= base + 32, 1'b1);
        if (csz(w) >= base + 32) begin
            for (int j = 0; j < 32; j++) begin
                chk($sformatf("byte%0d", j), (w == 0) ? cap0[base + j] : cap1[base + j], exp[j]);
            end
        end
    endtask

    initial begin
        logic [7:0] snap [32];
        logic [7:0] hello [5];
        int b;
        int d;
        int a;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; wen[i] = 1'b0; waddr[i] = 5'd0; wchar[i] = 8'h00;
            refresh[i] = 1'b0; fixlen[i] = 0; stuck[i] = 1'b0;
        end
        for (int j = 0; j < 32; j++) mbuf[j] = 8'h20;
        repeat (3) step();
        chk("rst_we", lwe[0], 1'b0);
        chk("rst_data", ldat[0], 8'h00);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_err", err[0], 1'b0);
        chk("rst_ar_busy", busy[1], 1'b0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        // Blank frame with a slow driver, plus first-byte latency.
        fixlen[0] = 100;
        refresh[0] = 1'b1;
        step();
        refresh[0] = 1'b0;
        chk("lat_we_early", lwe[0], 1'b0);
        step();
        chk("lat_we", lwe[0], 1'b1);
        chk("lat_busy", busy[0], 1'b1);
        wait_frames(0, 1, 5000);
        step();
        chk("blank_done_cnt", ndone[0], 1);
        chk("blank_busy_after", busy[0], 1'b0);
        cmp_frame(0, 0, mbuf);

        // HELLO then randomized text frames with random driver busy time.
        fixlen[0] = 0;
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        for (int k = 0; k < 4; k++) begin
            b = csz(0);
            d = ndone[0];
            if (k == 0) begin
                for (int j = 0; j < 5; j++) hwrite(0, 5'(j), hello[j]);
            end else begin
                repeat ($urandom_range(1, 6)) hwrite(0, 5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
            end
            rfr(0);
            wait_frames(0, d + 1, 2000);
            repeat (20) step();
            chk("text_done_cnt", ndone[0], d + 1);
            cmp_frame(0, b, mbuf);
        end

        // Three extra requests during one frame collapse into exactly one more frame.
        fixlen[0] = 5;
        b = csz(0);
        d = ndone[0];
        rfr(0);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(10, 40)) step();
            chk("busy_during_frame", busy[0], 1'b1);
            rfr(0);
        end
        wait_frames(0, d + 2, 3000);
        repeat (300) step();
        chk("collapse_done_cnt", ndone[0], d + 2);
        chk("collapse_bytes", csz(0), b + 64);
        chk("collapse_idle", busy[0], 1'b0);
        cmp_frame(0, b, mbuf);
        cmp_frame(0, b + 32, mbuf);

        // Overwrite the byte in flight: old value now, new value on the next frame.
        fixlen[0] = 20;
        a = $urandom_range(1, 30);
        hwrite(0, 5'(a), 8'h2A);
        snap = mbuf;
        b = csz(0);
        d = ndone[0];
        rfr(0);
        wait_cap(0, b + a + 1, 2000);
        repeat (3) step();
        hwrite(0, 5'(a), 8'h41);
        wait_frames(0, d + 1, 2000);
        cmp_frame(0, b, snap);
        rfr(0);
        wait_frames(0, d + 2, 2000);
        cmp_frame(0, b + 32, mbuf);

        // Driver never acknowledges: sticky error, frame dropped.
        stuck[0] = 1'b1;
        b = csz(0);
        d = ndone[0];
        rfr(0);
        wait_cap(0, b + 1, 100);
        repeat (3) step();
        chk("tmo_err_early", err[0], 1'b0);
        chk("tmo_busy_early", busy[0], 1'b1);
        repeat (9) step();
        chk("tmo_err", err[0], 1'b1);
        chk("tmo_idle", busy[0], 1'b0);
        chk("tmo_we", lwe[0], 1'b0);
        repeat (20) step();
        chk("tmo_err_sticky", err[0], 1'b1);
        chk("tmo_no_done", ndone[0], d);
        chk("tmo_one_byte", csz(0), b + 1);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("tmo_err_cleared", err[0], 1'b0);
        stuck[0] = 1'b0;

        // Auto-refresh instance: reset in the middle of a frame.
        d = ndone[1];
        b = csz(1);
        hwrite(1, 5'd7, 8'h51);
        wait_cap(1, b + 10, 500);
        rst[1] = 1'b1;
        step();
        chk("ar_rst_we", lwe[1], 1'b0);
        chk("ar_rst_data", ldat[1], 8'h00);
        chk("ar_rst_busy", busy[1], 1'b0);
        chk("ar_rst_done", done[1], 1'b0);
        chk("ar_rst_err", err[1], 1'b0);
        rst[1] = 1'b0;
        chk("ar_partial_no_done", ndone[1], d);
        b = csz(1);
        for (int j = 0; j < 32; j++) snap[j] = 8'h20;
        snap[3] = 8'h5A;
        hwrite(1, 5'd3, 8'h5A);
        wait_frames(1, d + 1, 1000);
        repeat (50) step();
        chk("ar_done_cnt", ndone[1], d + 1);
        cmp_frame(1, b, snap);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
